// File: rtl/icache_mem_arbiter_if.sv
// Bus bundle between the i-cache bank, the arbiter and the byte-serial instruction memory.
// The master modport is the arbiter's view; slave is the cache/memory environment's view.
interface icache_mem_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 28,
   parameter int DATA_W  = 128,
   parameter int ID_W    = 1
);
   logic [NUM_REQ-1:0]        req_read;
   logic [NUM_REQ*ADDR_W-1:0] req_address;
   logic [DATA_W-1:0]         req_readdata;
   logic [NUM_REQ-1:0]        req_busywait;
   logic                      mem_read;
   logic [ADDR_W-1:0]         mem_address;
   logic [DATA_W-1:0]         mem_readdata;
   logic                      mem_busywait;
   logic [ID_W-1:0]           owner;
   logic                      arb_busy;

   modport master (
      input  req_read, req_address, mem_readdata, mem_busywait,
      output req_readdata, req_busywait, mem_read, mem_address, owner, arb_busy
   );

   modport slave (
      output req_read, req_address, mem_readdata, mem_busywait,
      input  req_readdata, req_busywait, mem_read, mem_address, owner, arb_busy
   );
endinterface

// File: rtl/icache_mem_arbiter.sv
// Shares one byte-serial instruction memory between NUM_REQ i-caches, one 16-byte block at a time.
// Build option ICARB_FIXED_PRIO_EN: fixed priority (cache 0 highest) instead of round-robin.
module icache_mem_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 28,
   parameter int DATA_W  = 128,
   parameter int ID_W    = 1
) (
   input logic clock,
   input logic reset,
   icache_mem_arbiter_if.master bus
);
   // state   | meaning
   // IDLE    | no fetch in flight; owner and req_readdata hold
   // BUSY    | mem_read high while the memory streams 16 bytes
   // CAPTURE | block complete, registered into req_readdata
   // RESP    | owner's busywait released for exactly one cycle
   typedef enum logic [1:0] {IDLE, BUSY, CAPTURE, RESP} state_t;

   localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

   state_t              state, state_nxt;
   logic [ID_W-1:0]     owner, rr_ptr, rr_ptr_nxt, winner;
   logic                found;
   logic [ID_W:0]       win_sum;
   logic [NUM_REQ-1:0]  req_rot;
   logic [NUM_REQ-1:0]  busywait;
   logic [ADDR_W-1:0]   mem_address, sel_address;
   logic [DATA_W-1:0]   req_readdata;

   // Rotate so bit 0 is the cache at rr_ptr; the first set bit is the winner.
   always_comb begin
      req_rot = NUM_REQ'({bus.req_read, bus.req_read} >> rr_ptr);
      found   = 1'b0;
      winner  = '0;
      win_sum = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req_rot[k]) begin
            found   = 1'b1;
            win_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (win_sum >= NUM_REQ_W) win_sum = win_sum - NUM_REQ_W;
            winner  = win_sum[ID_W-1:0];
         end
      end
   end

   always_comb begin
      sel_address = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner == ID_W'(i)) sel_address = bus.req_address[i*ADDR_W +: ADDR_W];
      end
   end

`ifdef ICARB_FIXED_PRIO_EN
   // Pointer pinned at 0 turns the rotating search into lowest-index-first.
   assign rr_ptr_nxt = '0;
`else
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);
   assign rr_ptr_nxt = (owner == LAST_ID) ? '0 : owner + ID_W'(1);
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (found) state_nxt = BUSY;
         BUSY:    if (!bus.mem_busywait) state_nxt = CAPTURE;
         CAPTURE: state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         owner        <= '0;
         rr_ptr       <= '0;
         mem_address  <= '0;
         req_readdata <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && found) begin
            owner       <= winner;
            mem_address <= sel_address;
         end
         if (state == CAPTURE) req_readdata <= bus.mem_readdata;
         if (state == RESP) rr_ptr <= rr_ptr_nxt;
      end
   end

   always_comb begin
      busywait = bus.req_read;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (state == RESP && owner == ID_W'(i)) busywait[i] = 1'b0;
      end
   end

   assign bus.req_busywait = busywait;
   assign bus.req_readdata = req_readdata;
   assign bus.mem_read     = (state == BUSY);
   assign bus.mem_address  = mem_address;
   assign bus.owner        = owner;
   assign bus.arb_busy     = (state != IDLE);
endmodule

// File: tb/tb_icache_mem_arbiter.sv
// Bench for icache_mem_arbiter: byte-serial memory model plus a transaction-level reference
// (fixed 18-cycle fetch latency, modular arbitration search) compared every cycle.
module tb_icache_mem_arbiter;
   localparam int N  = 2;
   localparam int AW = 28;
   localparam int DW = 128;
   localparam int IW = 1;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   icache_mem_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) bus ();

   icache_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // byte-serial instruction memory: one byte per cycle while mem_read, busywait low on byte 15
   logic [7:0]    mem [256];
   logic [3:0]    mcnt = 4'd0;
   logic [DW-1:0] mbuf = '0;

   always @(posedge clock) begin
      if (reset) mcnt <= 4'd0;
      else if (bus.mem_read) begin
         mbuf[int'(mcnt)*8 +: 8] <= mem[{bus.mem_address[3:0], mcnt}];
         mcnt <= mcnt + 4'd1;
      end
   end
   assign bus.mem_busywait = bus.mem_read && (mcnt != 4'hF);
   assign bus.mem_readdata = mbuf;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         if (n_errors <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // stimulus
   logic [N-1:0]  r;
   logic [AW-1:0] a [N];
   bit            auto_clear;

   // reference model: a fetch occupies 18 cycles after its grant; k counts them
   bit            m_active;
   int            m_k, m_owner, m_ptr;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;

   // observations
   int            cyc;
   int            resp_cyc [N];
   logic [DW-1:0] resp_data [N];
   int            bw_low_cnt [N];
   int            mem_read_cnt;
   bit            prev_busy;
   int            own_q [$];

   function automatic logic [DW-1:0] blk(input logic [AW-1:0] addr);
      logic [DW-1:0] b;
      logic [3:0]    ba;
      b  = '0;
      ba = addr[3:0];
      for (int k = 0; k < 16; k++) b[k*8 +: 8] = mem[{ba, 4'(k)}];
      return b;
   endfunction

   function automatic int pick(input logic [N-1:0] rq, input int ptr);
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (ptr + k) % N;
         if (rq[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_active = 1'b0;
      m_k      = 0;
      m_owner  = 0;
      m_ptr    = 0;
      m_addr   = '0;
      m_data   = '0;
   endtask

   task automatic model_advance();
      int w;
      if (reset) model_reset();
      else if (!m_active) begin
         w = pick(r, m_ptr);
         if (w >= 0) begin
            m_owner  = w;
            m_addr   = a[w];
            m_active = 1'b1;
            m_k      = 1;
         end
      end else if (m_k == 18) begin
         m_active = 1'b0;
`ifdef ICARB_FIXED_PRIO_EN
         m_ptr = 0;
`else
         m_ptr = (m_owner + 1) % N;
`endif
         if (auto_clear) r[m_owner] = 1'b0;
      end else begin
         if (m_k == 17) m_data = blk(m_addr);
         m_k++;
      end
   endtask

   task automatic apply();
      bus.req_read = r;
      for (int i = 0; i < N; i++) bus.req_address[i*AW +: AW] = a[i];
   endtask

   task automatic compare_cycle();
      logic [N-1:0] exp_bw;
      exp_bw = r;
      if (m_active && m_k == 18) exp_bw[m_owner] = 1'b0;
      check_eq("arb_busy",     DW'(bus.arb_busy),     DW'(m_active));
      check_eq("mem_read",     DW'(bus.mem_read),     DW'(m_active && m_k <= 16));
      check_eq("mem_address",  DW'(bus.mem_address),  DW'(m_addr));
      check_eq("owner",        DW'(bus.owner),        DW'(m_owner));
      check_eq("req_busywait", DW'(bus.req_busywait), DW'(exp_bw));
      check_eq("req_readdata", bus.req_readdata,      m_data);
      if (bus.mem_read) mem_read_cnt++;
      for (int i = 0; i < N; i++) begin
         if (r[i] && !bus.req_busywait[i]) begin
            resp_cyc[i]  = cyc;
            resp_data[i] = bus.req_readdata;
            bw_low_cnt[i]++;
         end
      end
      if (bus.arb_busy && !prev_busy) own_q.push_back(int'(bus.owner));
      prev_busy = bus.arb_busy;
   endtask

   task automatic step();
      apply();
      @(negedge clock);
      compare_cycle();
      @(posedge clock);
      model_advance();
      cyc++;
      #1;
   endtask

   task automatic clear_obs();
      cyc          = 0;
      mem_read_cnt = 0;
      own_q.delete();
      for (int i = 0; i < N; i++) begin
         resp_cyc[i]   = -1;
         resp_data[i]  = '0;
         bw_low_cnt[i] = 0;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      r     = '0;
      step();
      reset = 1'b0;
      clear_obs();
   endtask

   int exp_own [4];

   initial begin
      for (int j = 0; j < 256; j++) mem[j] = 8'($urandom);
      for (int k = 0; k < 16; k++) mem[16 + k] = 8'(16 + k);
      r          = '0;
      auto_clear = 1'b0;
      prev_busy  = 1'b0;
      for (int i = 0; i < N; i++) a[i] = '0;
      model_reset();
      clear_obs();
      apply();
      @(posedge clock);
      #1;
      do_reset();

      // single request from cache 0, block 1
      a[0] = 28'h0000001;
      r    = 2'b01;
      for (int c = 0; c < 19; c++) step();
      r = '0;
      check_eq("single_mem_read_cycles", DW'(mem_read_cnt), DW'(16));
      check_eq("single_bw_low_cycles",   DW'(bw_low_cnt[0]), DW'(1));
      check_eq("single_resp_cycle",      DW'(resp_cyc[0]), DW'(18));
      check_eq("single_data", resp_data[0], 128'h1F1E1D1C1B1A19181716151413121110);
      for (int c = 0; c < 3; c++) step();

      // contention: both caches, served in turn
      do_reset();
      auto_clear = 1'b1;
      a[0] = 28'd0;
      a[1] = 28'd1;
      r    = 2'b11;
      for (int c = 0; c < 40; c++) step();
      check_eq("cont_resp_cycle0", DW'(resp_cyc[0]), DW'(18));
      check_eq("cont_resp_cycle1", DW'(resp_cyc[1]), DW'(37));
      check_eq("cont_data0", resp_data[0], blk(28'd0));
      check_eq("cont_data1", resp_data[1], blk(28'd1));

      // fairness: continuous requests from both
      do_reset();
      auto_clear = 1'b0;
      a[0] = 28'd2;
      a[1] = 28'd3;
      r    = 2'b11;
      for (int c = 0; c < 76; c++) step();
      r = '0;
`ifdef ICARB_FIXED_PRIO_EN
      exp_own = '{0, 0, 0, 0};
`else
      exp_own = '{0, 1, 0, 1};
`endif
      check_eq("fair_grant_count", DW'(own_q.size()), DW'(4));
      for (int g = 0; g < 4; g++) begin
         check_eq($sformatf("fair_owner%0d", g),
                  DW'(g < own_q.size() ? own_q[g] : -1), DW'(exp_own[g]));
      end
      for (int c = 0; c < 20; c++) step();

      // abort: cache 1 drops its request during the fetch
      do_reset();
      auto_clear = 1'b1;
      a[1] = 28'd3;
      r    = 2'b10;
      for (int c = 0; c < 6; c++) step();
      r[1] = 1'b0;
      for (int c = 6; c < 19; c++) step();
      a[0] = 28'd2;
      r[0] = 1'b1;
      for (int c = 19; c < 40; c++) step();
      check_eq("abort_no_release1", DW'(bw_low_cnt[1]), DW'(0));
      check_eq("abort_resp_cycle0", DW'(resp_cyc[0]), DW'(37));
      check_eq("abort_data0", resp_data[0], blk(28'd2));

      // reset in the middle of a fetch
      do_reset();
      a[0] = 28'd4;
      r    = 2'b01;
      for (int c = 0; c < 9; c++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_eq("rst_mid_mem_read", DW'(bus.mem_read), DW'(0));
      check_eq("rst_mid_arb_busy", DW'(bus.arb_busy), DW'(0));
      check_eq("rst_mid_readdata", bus.req_readdata, '0);
      clear_obs();
      a[0] = 28'd5;
      r    = 2'b01;
      for (int c = 0; c < 22; c++) step();
      check_eq("rst_mid_resp_cycle", DW'(resp_cyc[0]), DW'(18));
      check_eq("rst_mid_data", resp_data[0], blk(28'd5));

      // idle
      do_reset();
      auto_clear = 1'b0;
      r = '0;
      for (int c = 0; c < 25; c++) step();
      check_eq("idle_mem_read_cycles", DW'(mem_read_cnt), DW'(0));

      // random traffic, drops, address changes, rare resets
      auto_clear = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 499) == 0);
         for (int i = 0; i < N; i++) begin
            if (!r[i] && $urandom_range(0, 7) == 0) begin
               r[i] = 1'b1;
               a[i] = AW'($urandom_range(0, 15));
            end else if (r[i] && $urandom_range(0, 63) == 0) begin
               r[i] = 1'b0;
            end
            if ($urandom_range(0, 31) == 0) a[i] = AW'($urandom_range(0, 15));
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
